// File: rtl/csa_resolve_90.sv
// Carry-propagate resolver: turns a W-bit carry-save pair into binary, CHUNK bits per cycle.
// Handshaked on both sides; one operand pair in flight at a time.
module csa_resolve_90 #(
  parameter int W     = 90,
  parameter int CHUNK = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] s_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam int NCH = W / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k_p1;
  logic            carry_p1;
  logic [W-1:0]    c_p0, s_p0;
  logic [W-1:0]    sum_p1;
  logic            ovf_p1;
  logic [CHUNK:0]  add_res;
  logic            accept;
  logic            last_chunk;

  // One CHUNK-bit add with carry-in; bit CHUNK is the carry-out.
  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             ci);
    chunk_add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  endfunction

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (k_p1 == KLAST);
  assign sum        = sum_p1;
  assign ovf        = ovf_p1;

  // The operands shift right so the active chunk always sits in the low bits.
  assign add_res = chunk_add(c_p0[CHUNK-1:0], s_p0[CHUNK-1:0], carry_p1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = RUN;
      RUN:     if (last_chunk) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture and per-chunk shift.
  always_ff @(posedge clk) begin
    if (accept) begin
      c_p0 <= c_in;
      s_p0 <= s_in;
    end else if (state == RUN) begin
      c_p0 <= c_p0 >> CHUNK;
      s_p0 <= s_p0 >> CHUNK;
    end
  end

  // Stage p1: control, running carry and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_p1     <= '0;
      carry_p1 <= 1'b0;
      sum_p1   <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            k_p1     <= '0;
            carry_p1 <= 1'b0;
          end
        end
        RUN: begin
          carry_p1 <= add_res[CHUNK];
          for (int i = 0; i < NCH; i++) begin
            if (k_p1 == KW'(i)) sum_p1[i*CHUNK +: CHUNK] <= add_res[CHUNK-1:0];
          end
          if (last_chunk) begin
            ovf_p1 <= add_res[CHUNK];
            k_p1   <= '0;
          end else begin
            k_p1 <= k_p1 + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve_90.sv
// Directed and randomized bench for csa_resolve_90 with a result scoreboard.
module tb_csa_resolve_90;

  localparam int W = 90;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] c_in;
  logic [W-1:0] s_in;
  logic         out_valid;
  wire          out_ready;
  logic [W-1:0] sum;
  logic         ovf;

  logic dir_ready, rnd_ready, rnd_mode;
  assign out_ready = rnd_mode ? rnd_ready : dir_ready;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W:0] sb[$];

  csa_resolve_90 #(.W(W), .CHUNK(30)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c_in(c_in), .s_in(s_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand90();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Reference: plain 91-bit addition of the pair.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Holds in_valid until accepted; returns #1 after the accepting edge with in_valid low.
  task automatic send(input logic [W-1:0] c, input logic [W-1:0] s, input logic [W:0] exp);
    bit done;
    done = 0;
    c_in = c;
    s_in = s;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout: observed=no_accept expected=accept");
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      tick();
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    chk("drain_empty", {127'd0, done}, 128'd1);
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL result_unexpected: observed=%0h expected=none", {ovf, sum});
      end else begin
        e = sb.pop_front();
        chk("result", {37'd0, ovf, sum}, {37'd0, e});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [W-1:0] x, y, z, cc, ss;
    logic [W:0] e;
    rst_n = 1'b0; in_valid = 1'b0; c_in = '0; s_in = '0;
    dir_ready = 1'b0; rnd_mode = 1'b0; rnd_ready = 1'b0;

    tick(); tick(); tick();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_sum", {38'd0, sum}, 128'd0);
    chk("rst_ovf", {127'd0, ovf}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Basic latency and in_ready behaviour.
    send(90'd0, 90'd5, 91'd5);
    chk("basic_rdy_T", {127'd0, in_ready}, 128'd0);
    tick();
    chk("basic_vld_T1", {127'd0, out_valid}, 128'd0);
    chk("basic_rdy_T1", {127'd0, in_ready}, 128'd0);
    tick();
    chk("basic_vld_T2", {127'd0, out_valid}, 128'd0);
    tick();
    chk("basic_vld_T3", {127'd0, out_valid}, 128'd1);
    chk("basic_rdy_T3", {127'd0, in_ready}, 128'd0);
    chk("basic_sum_T3", {38'd0, sum}, 128'd5);
    dir_ready = 1'b1;
    tick();
    chk("basic_vld_exit", {127'd0, out_valid}, 128'd0);
    chk("basic_rdy_exit", {127'd0, in_ready}, 128'd1);

    // Chunk-boundary carries and full ripple.
    send(90'd1 << 29, 90'd1 << 29, 91'd1 << 30);
    send(90'd1 << 59, 90'd1 << 59, 91'd1 << 60);
    send(90'd1, {W{1'b1}}, 91'd1 << 90);
    send(90'd1 << 89, 90'd1 << 89, 91'd1 << 90);
    drain();

    // Back-pressure in DONE with noisy inputs.
    dir_ready = 1'b0;
    cc = rand90(); ss = rand90();
    e = ref_add(cc, ss);
    send(cc, ss, e);
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      c_in = rand90();
      s_in = rand90();
      tick();
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_result", {37'd0, ovf, sum}, {37'd0, e});
    end
    in_valid = 1'b0;
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    chk("bp_exit_rdy", {127'd0, in_ready}, 128'd1);
    chk("bp_exit_vld", {127'd0, out_valid}, 128'd0);
    tick(); tick(); tick(); tick();
    chk("bp_none_taken", {127'd0, out_valid}, 128'd0);
    dir_ready = 1'b1;

    // Reset during the second RUN cycle.
    c_in = rand90(); s_in = rand90(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_vld", {127'd0, out_valid}, 128'd0);
    chk("mrst_sum", {38'd0, sum}, 128'd0);
    chk("mrst_ovf", {127'd0, ovf}, 128'd0);
    chk("mrst_rdy", {127'd0, in_ready}, 128'd1);
    tick(); tick(); tick(); tick();
    chk("mrst_no_pulse", {127'd0, out_valid}, 128'd0);
    cc = rand90(); ss = rand90();
    send(cc, ss, ref_add(cc, ss));
    drain();

    // End-to-end through a carry-save stage with random stalls.
    rnd_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      x = rand90(); y = rand90(); z = rand90();
      ss = x ^ y ^ z;
      cc = ((x & y) | (x & z) | (y & z)) << 1;
      e = ref_add(cc, ss);
      e[W-1:0] = x + y + z;
      send(cc, ss, e);
    end
    drain();
    rnd_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_resolve_90.md
# csa_resolve_90

Sequential carry-propagate resolver that converts a 90-bit carry-save pair (carry vector `c`, sum vector `s`) into a single binary word. It computes `c + s` mod 2^90 in chunks of `CHUNK` bits per cycle, which keeps the carry chain short enough for the target clock. It sits at the output of the carry-save multiplier/accumulator trees. There it turns their redundant result back into binary before the result goes to the reducer or leaves the datapath.

## Interface

Parameters:
- `W`, 90, operand/result width in bits.
- `CHUNK`, 30, bits resolved per cycle. `W` must be an integer multiple of `CHUNK`, so `NCH = W/CHUNK` (3 by default).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `in_valid`  input  1  a redundant operand pair is presented.
- `in_ready`  output  1  the block can accept an operand pair.
- `c_in`  input  W  carry vector of the carry-save pair.
- `s_in`  input  W  sum vector of the carry-save pair.
- `out_valid`  output  1  `sum`/`ovf` hold a resolved result.
- `out_ready`  input  1  the consumer accepts the result.
- `sum`  output  W  `(c_in + s_in) mod 2^W`.
- `ovf`  output  1  carry out of bit W-1; 1 when `c_in + s_in >= 2^W`.

## Operation

- State machine with three states: IDLE, RUN, DONE.
- Reset (`rst_n`=0 at a clock edge):
  - state goes to IDLE, `out_valid`=0, `sum`=0, `ovf`=0.
  - internal chunk index and running carry are cleared.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `c_in` and `s_in`, clear the running carry and the chunk index `k`, and go to RUN.
- RUN:
  - `in_ready`=0.
  - Each cycle: `{carry', sum[k*CHUNK +: CHUNK]} = c[k*CHUNK +: CHUNK] + s[k*CHUNK +: CHUNK] + carry`, then `k` increments.
  - After the cycle with `k = NCH-1`: `ovf` gets the final carry, and the state goes to DONE.
- DONE:
  - `out_valid`=1; `in_ready`=0.
  - `sum` and `ovf` are held stable until `out_ready`=1.
  - On `out_valid && out_ready`: go to IDLE. `out_valid` drops on the next cycle.
- No assumption is made about `c_in[0]`. Any pair of vectors is summed, whether or not it came from a CSA stage with `c[0]`=0.
- `c_in` and `s_in` are ignored except on the accept cycle. Changing them during RUN or DONE has no effect.
- `in_valid` asserted while `in_ready`=0 is not consumed. The upstream holds its data until the handshake completes.
- `sum` outside DONE is don't-care for the consumer. It may show partially resolved chunks during RUN.

## Timing

- `in_ready` is derived combinationally from state (IDLE only). It is 1 on the first cycle after reset.
- Latency: accept at edge T gives `out_valid`=1 after edge T+NCH (3 cycles by default).
- Throughput: at most one result every NCH+2 cycles (accept, NCH resolve cycles, DONE handshake), i.e. 5 cycles at defaults.
- Back-pressure: DONE is held indefinitely while `out_ready`=0; no input is accepted meanwhile.
- `out_ready` asserted outside DONE is ignored.
- Reset mid-operation (in RUN or DONE): the operation is abandoned, no `out_valid` pulse appears, and the block is in IDLE with `in_ready`=1 on the next cycle.
- Critical path: one CHUNK-bit adder plus carry-in. No path spans more than CHUNK bits of carry propagation.

## Test plan

- Basic: accept `c`=0, `s`=5 at edge T.
  - Required: `out_valid` rises after T+3 with `sum`=5 and `ovf`=0.
  - Required: `in_ready`=0 from T+1 until DONE is left.
- Chunk-boundary carry: `c`=2^29, `s`=2^29.
  - Required: `sum`=2^30, `ovf`=0.
  - Repeat with `c`=`s`=2^59: required `sum`=2^60.
- Full ripple: `s`=2^90-1, `c`=1.
  - Required: `sum`=0, `ovf`=1.
  - Also `c`=`s`=2^89: required `sum`=0, `ovf`=1.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE while toggling `in_valid`, `c_in` and `s_in`.
  - Required: `sum` and `ovf` unchanged, `in_ready`=0, nothing accepted.
  - Then `out_ready`=1 for one cycle: required return to IDLE with `in_ready`=1.
- Reset mid-run: assert `rst_n`=0 for one edge during the second RUN cycle.
  - Required: next cycle `out_valid`=0, `sum`=0, `ovf`=0, `in_ready`=1.
  - A fresh operand pair then resolves correctly.
- End-to-end: 1000 random `x`, `y`, `z` passed through the 90-bit carry-save adder, feeding its `c`/`s` in here with random `out_ready` stalls.
  - Required: every `sum` equals `(x+y+z) mod 2^90`.
  - Required: results come out in order, with none dropped or duplicated.
